// File: rtl/ps2_pkg.sv
// PS/2 host transmitter shared definitions.
// State encoding, device command bytes and default cycle counts.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;

  localparam int unsigned PS2_CLK_HZ         = 100_000_000;
  localparam int unsigned PS2_INHIBIT_CYCLES = 12_000;
  localparam int unsigned PS2_TIMEOUT_CYCLES = 2_000_000;

  // Falling clock edge that releases data for the stop bit.
  localparam logic [3:0] PS2_STOP_EDGE = 4'd10;

  // Odd parity: the nine transmitted bits carry an odd number of ones.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronizer for one raw PS/2 line.
// Also flags a falling edge of the synchronized level.
module ps2_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic line_in,
  output logic level,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // Resample the asynchronous line; idle bus level is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= 1'b1;
      sync <= 1'b1;
      prev <= 1'b1;
    end else begin
      meta <= line_in;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign fall  = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device byte transmitter.
// Inhibits the clock, requests to send, shifts a frame, checks ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned CLK_HZ         = PS2_CLK_HZ,
  parameter int unsigned INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_low,
  output logic       ps2_data_low,
  output logic       tx_done,
  output logic       tx_err
);

  localparam int unsigned INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [INH_W-1:0] INH_LAST =
    INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_LAST =
    TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_MAX =
    TO_W'(TIMEOUT_CYCLES);

  if (CLK_HZ == 0 || INHIBIT_CYCLES == 0 ||
      TIMEOUT_CYCLES < 2) begin : g_bad_params
    $error("ps2_host_tx: invalid cycle parameters");
  end

  ps2_tx_state_t    state_q, state_d;
  logic [7:0]       data_q, data_d;
  logic             par_q, par_d;
  logic [INH_W-1:0] inh_q, inh_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [3:0]       bit_q, bit_d;
  logic             low_q, low_d;

  logic clk_lvl;
  logic clk_fall;
  logic dat_lvl;
  logic dat_fall;
  logic timed_out;
  logic bus_idle;
  logic next_bit;
  logic done_c;
  logic err_c;
  logic ready_c;
  logic clk_low_c;
  logic data_low_c;

  ps2_sync_edge u_sync_clk (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_clk_in),
    .level   (clk_lvl),
    .fall    (clk_fall)
  );

  ps2_sync_edge u_sync_data (
    .clk     (clk),
    .rst     (rst),
    .line_in (ps2_data_in),
    .level   (dat_lvl),
    .fall    (dat_fall)
  );

  assign timed_out = (to_q >= TO_LAST);

  // Bus counts as idle only when both lines sit steadily high.
  assign bus_idle = clk_lvl & dat_lvl & ~clk_fall & ~dat_fall;

  // Bit presented after the next falling edge: d0..d7, parity, stop.
  always_comb begin
    next_bit = 1'b1;
    if (bit_q < 4'd8) begin
      next_bit = data_q[bit_q[2:0]];
    end else if (bit_q == 4'd8) begin
      next_bit = par_q;
    end
  end

  // Next-state, datapath updates and line drives for the transfer FSM.
  always_comb begin
    state_d    = state_q;
    data_d     = data_q;
    par_d      = par_q;
    inh_d      = inh_q;
    to_d       = to_q;
    bit_d      = bit_q;
    low_d      = low_q;
    done_c     = 1'b0;
    err_c      = 1'b0;
    ready_c    = 1'b0;
    clk_low_c  = 1'b0;
    data_low_c = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        ready_c = 1'b1;
        inh_d   = '0;
        if (tx_valid) begin
          data_d  = tx_data;
          par_d   = ps2_odd_parity(tx_data);
          state_d = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        clk_low_c = 1'b1;
        if (inh_q >= INH_LAST) begin
          data_low_c = 1'b1;
          state_d    = ST_START;
        end else begin
          inh_d = inh_q + INH_W'(1);
        end
      end

      ST_START: begin
        data_low_c = 1'b1;
        low_d      = 1'b1;
        bit_d      = '0;
        to_d       = '0;
        state_d    = ST_SEND;
      end

      ST_SEND: begin
        data_low_c = low_q;
        if (timed_out) begin
          data_low_c = 1'b0;
          done_c     = 1'b1;
          err_c      = 1'b1;
          state_d    = ST_IDLE;
        end else begin
          if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
          end
          if (clk_fall) begin
            low_d = ~next_bit;
            if (bit_q != 4'hF) begin
              bit_d = bit_q + 4'd1;
            end
            if (bit_q == PS2_STOP_EDGE - 4'd1) begin
              state_d = ST_ACK;
            end
          end
        end
      end

      ST_ACK: begin
        if (timed_out) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
          end
          if (clk_fall) begin
            if (!dat_lvl) begin
              state_d = ST_WAIT_IDLE;
            end else begin
              done_c  = 1'b1;
              err_c   = 1'b1;
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_WAIT_IDLE: begin
        if (timed_out) begin
          done_c  = 1'b1;
          err_c   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          if (to_q != TO_MAX) begin
            to_d = to_q + TO_W'(1);
          end
          if (bus_idle) begin
            done_c  = 1'b1;
            state_d = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset returns to an idle bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      par_q   <= 1'b0;
      inh_q   <= '0;
      to_q    <= '0;
      bit_q   <= '0;
      low_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      par_q   <= par_d;
      inh_q   <= inh_d;
      to_q    <= to_d;
      bit_q   <= bit_d;
      low_q   <= low_d;
    end
  end

  assign tx_ready     = ready_c;
  assign ps2_clk_low  = clk_low_c;
  assign ps2_data_low = data_low_c;
  assign tx_done      = done_c & ~rst;
  assign tx_err       = err_c & ~rst;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx with a PS/2 device model.
// Expected frame bits and results are queued and checked on the bus.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 120;
  localparam int TMO  = 3000;
  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_low;
  logic       ps2_data_low;
  logic       tx_done;
  logic       tx_err;

  always #5 clk = ~clk;

  assign ps2_clk_in  = dev_clk & ~ps2_clk_low;
  assign ps2_data_in = dev_data & ~ps2_data_low;

  ps2_host_tx #(
    .CLK_HZ         (100_000_000),
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .ps2_clk_in   (ps2_clk_in),
    .ps2_data_in  (ps2_data_in),
    .ps2_clk_low  (ps2_clk_low),
    .ps2_data_low (ps2_data_low),
    .tx_done      (tx_done),
    .tx_err       (tx_err)
  );

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   rel_cyc = 0;
  int   inh_len = 0;
  logic inh_first = 1'b0;
  logic inh_last = 1'b0;
  logic prev_clk_low = 1'b0;
  logic prev_done = 1'b0;
  bit   busy_end = 1'b0;

  logic exp_bits[$];
  logic exp_err[$];

  task automatic chk(input string tag, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  task automatic push_frame(input logic [7:0] d);
    int ones;
    ones = 0;
    for (int i = 0; i < 8; i++) begin
      exp_bits.push_back(d[i]);
      if (d[i]) ones++;
    end
    exp_bits.push_back((ones % 2) == 0);
    exp_bits.push_back(1'b1);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Bus monitor: accepts, inhibit timing, completion results.
  always @(negedge clk) begin
    if (!rst) begin
      if (tx_valid && tx_ready) begin
        acc_cnt++;
        push_frame(tx_data);
      end
      if (ps2_clk_low) begin
        if (inh_len == 0) inh_first = ps2_data_low;
        inh_len++;
        inh_last = ps2_data_low;
      end else if (prev_clk_low) begin
        chk("inhibit_len", inh_len, INH);
        chk("inhibit_data_first", int'(inh_first), 0);
        chk("inhibit_data_last", int'(inh_last), 1);
        rel_cyc = cyc;
        inh_len = 0;
      end
      if (prev_done) begin
        chk("ready_after_done", int'(tx_ready), 1);
        chk("clk_released", int'(ps2_clk_low), 0);
        chk("data_released", int'(ps2_data_low), 0);
        chk("done_single", int'(tx_done), 0);
      end
      if (tx_done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("done_expected", int'(exp_err.size() > 0), 1);
        if (exp_err.size() > 0)
          chk("tx_err", int'(tx_err), int'(exp_err.pop_front()));
      end
      prev_done    = tx_done;
      prev_clk_low = ps2_clk_low;
    end
  end

  task automatic wait_clk(input logic lvl, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 5000 && !seen; i++) begin
      if (ps2_clk_in === lvl) seen = 1'b1;
      else @(negedge clk);
    end
    chk(tag, int'(ps2_clk_in), int'(lvl));
  endtask

  task automatic wait_done(input int target, input int limit);
    for (int i = 0; i < limit && done_cnt < target; i++)
      @(negedge clk);
    chk("done_seen", int'(done_cnt >= target), 1);
  endtask

  task automatic wait_acc(input int target);
    for (int i = 0; i < 5000 && acc_cnt < target; i++)
      @(negedge clk);
    chk("accept_seen", int'(acc_cnt >= target), 1);
  endtask

  task automatic send_byte(input logic [7:0] d);
    int t;
    @(posedge clk);
    #1;
    tx_data  = d;
    tx_valid = 1'b1;
    t = acc_cnt + 1;
    wait_acc(t);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  // Device side: wait for request-to-send, clock out, optionally ACK.
  task automatic dev_frame(input int npulse, input bit ack);
    logic have;
    wait_clk(1'b0, "req_inhibit");
    wait_clk(1'b1, "req_release");
    repeat (4) @(negedge clk);
    chk("start_bit", int'(ps2_data_in), 0);
    chk("busy_not_ready", int'(tx_ready), 0);
    for (int i = 0; i < npulse; i++) begin
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      have = exp_bits.size() > 0;
      chk("bit_expected", int'(have), 1);
      if (have)
        chk($sformatf("frame_bit%0d", i), int'(ps2_data_in),
            int'(exp_bits.pop_front()));
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    if (npulse == 10) begin
      if (ack) dev_data = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_data = 1'b1;
    end
  endtask

  task automatic full_xfer(input logic [7:0] d, input bit ack);
    int t;
    t = done_cnt + 1;
    exp_err.push_back(!ack);
    send_byte(d);
    dev_frame(10, ack);
    wait_done(t, 2000);
  endtask

  initial begin
    int t;
    int saved;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", int'(tx_ready), 1);
    chk("rst_clk_low", int'(ps2_clk_low), 0);
    chk("rst_data_low", int'(ps2_data_low), 0);
    chk("rst_done", int'(tx_done), 0);
    chk("rst_err", int'(tx_err), 0);
    rst = 1'b0;
    repeat (5) @(posedge clk);

    full_xfer(PS2_CMD_SET_LEDS, 1'b1);
    full_xfer(PS2_CMD_ENABLE, 1'b1);
    full_xfer(8'h5A, 1'b0);

    // Device never clocks: watchdog must end the transfer.
    t = done_cnt + 1;
    exp_err.push_back(1'b1);
    send_byte(8'h3C);
    wait_clk(1'b0, "to_inhibit");
    wait_clk(1'b1, "to_release");
    wait_done(t, TMO + 500);
    chk("timeout_cycles", done_cyc - rel_cyc, TMO);
    chk("timeout_no_bits", exp_bits.size(), 10);
    exp_bits.delete();

    // Reset after edge 5 of an 8'hFF transfer.
    exp_err.push_back(1'b0);
    send_byte(PS2_CMD_RESET);
    dev_frame(5, 1'b1);
    saved = done_cnt;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_clk_low", int'(ps2_clk_low), 0);
    chk("abort_data_low", int'(ps2_data_low), 0);
    chk("abort_ready", int'(tx_ready), 1);
    exp_bits.delete();
    exp_err.delete();
    repeat (200) @(posedge clk);
    chk("abort_no_done", done_cnt, saved);
    full_xfer(8'h00, 1'b1);

    // tx_valid held with changing data: one byte per idle window.
    t = done_cnt + 2;
    exp_err.push_back(1'b0);
    exp_err.push_back(1'b0);
    @(posedge clk);
    #1;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    busy_end = 1'b0;
    fork
      begin
        dev_frame(10, 1'b1);
        busy_end = 1'b1;
      end
      begin
        while (!busy_end) begin
          @(posedge clk);
          #1;
          tx_data = 8'($urandom);
        end
      end
    join
    wait_acc(acc_cnt + 1);
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    dev_frame(10, 1'b1);
    wait_done(t, 2000);

    repeat (20) @(posedge clk);
    chk("bits_left", exp_bits.size(), 0);
    chk("results_left", exp_err.size(), 0);
    chk("accept_count", acc_cnt, 8);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
